// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants for the register-file writeback arbiter and its scoreboard.
package regfile_wb_arbiter_pkg;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned NREG   = 32;
    localparam int unsigned XLEN   = 32;

    localparam logic [REG_AW-1:0] X0_ADDR = '0;

    function automatic logic is_x0(input logic [REG_AW-1:0] addr);
        return addr == X0_ADDR;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// NREQ-wide round-robin arbiter: one-hot combinational grant, pointer
// advances past the winner whenever a grant is given.
module rr_arbiter #(
    parameter int unsigned NREQ = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req_i,
    output logic [NREQ-1:0] grant_c_o
);

    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [PTR_W-1:0] sel;
    logic             found;
    int unsigned      idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Scan from the pointer upward, wrapping modulo NREQ; first valid wins.
    always_comb begin
        grant_c_o = '0;
        ptr_d     = ptr_q;
        found     = 1'b0;
        idx       = 0;
        sel       = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(ptr_q) + k) % NREQ;
            sel = PTR_W'(idx);
            if (!found && req_i[sel]) begin
                grant_c_o[sel] = 1'b1;
                ptr_d          = PTR_W'((idx + 1) % NREQ);
                found          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among NREQ writeback requesters and
// tracks per-register pending writes for decode-stage RAW/WAW stalls.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned XLEN = regfile_wb_arbiter_pkg::XLEN,
    parameter int unsigned NREG = regfile_wb_arbiter_pkg::NREG
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [REG_AW*NREQ-1:0] req_addr,
    input  logic [XLEN*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]        req_ready,
    input  logic                   rsv_valid,
    input  logic [REG_AW-1:0]      rsv_addr,
    output logic                   rsv_ready,
    input  logic [REG_AW-1:0]      q_a1,
    input  logic [REG_AW-1:0]      q_a2,
    output logic                   q_busy1,
    output logic                   q_busy2,
    output logic                   rf_we,
    output logic [REG_AW-1:0]      rf_a3,
    output logic [XLEN-1:0]        rf_wd3
);

    logic [NREQ-1:0]   grant;
    logic              xfer;
    logic [REG_AW-1:0] gnt_addr;
    logic [XLEN-1:0]   gnt_data;

    logic              we_q,  we_d;
    logic [REG_AW-1:0] a3_q,  a3_d;
    logic [XLEN-1:0]   wd3_q, wd3_d;

    logic [NREG-1:1]   busy_q, busy_d;
    logic [NREG-1:0]   busy_vec;
    logic              rsv_set;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req_i     (req_valid),
        .grant_c_o (grant)
    );

    assign req_ready = grant;
    assign xfer      = |grant;

    // Select the granted requester's payload.
    always_comb begin
        gnt_addr = '0;
        gnt_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                gnt_addr = req_addr[REG_AW*i +: REG_AW];
                gnt_data = req_data[XLEN*i +: XLEN];
            end
        end
    end

    // x0 writes are accepted but never reach the register file.
    always_comb begin
        we_d  = xfer && !is_x0(gnt_addr);
        a3_d  = a3_q;
        wd3_d = wd3_q;
        if (we_d) begin
            a3_d  = gnt_addr;
            wd3_d = gnt_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q  <= 1'b0;
            a3_q  <= '0;
            wd3_q <= '0;
        end else begin
            we_q  <= we_d;
            a3_q  <= a3_d;
            wd3_q <= wd3_d;
        end
    end

    assign rf_we  = we_q;
    assign rf_a3  = a3_q;
    assign rf_wd3 = wd3_q;

    // x0 reads as never busy.
    assign busy_vec  = {busy_q, 1'b0};
    assign rsv_ready = rsv_valid && !busy_vec[rsv_addr];
    assign rsv_set   = rsv_ready && !is_x0(rsv_addr);
    assign q_busy1   = busy_vec[q_a1];
    assign q_busy2   = busy_vec[q_a2];

    // Clear tracks the register-file write edge; a same-edge reserve wins.
    always_comb begin
        busy_d = busy_q;
        for (int unsigned r = 1; r < NREG; r++) begin
            busy_d[r] = (busy_q[r] && !(we_q && (a3_q == REG_AW'(r))))
                      || (rsv_set && (rsv_addr == REG_AW'(r)));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed, table-driven bench for regfile_wb_arbiter (NREQ=2).
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [9:0]  req_addr;
    logic [63:0] req_data;
    logic [1:0]  req_ready;
    logic        rsv_valid;
    logic [4:0]  rsv_addr;
    logic        rsv_ready;
    logic [4:0]  q_a1, q_a2;
    logic        q_busy1, q_busy2;
    logic        rf_we;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.NREQ(2), .XLEN(32), .NREG(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .rsv_ready (rsv_ready),
        .q_a1      (q_a1),
        .q_a2      (q_a2),
        .q_busy1   (q_busy1),
        .q_busy2   (q_busy2),
        .rf_we     (rf_we),
        .rf_a3     (rf_a3),
        .rf_wd3    (rf_wd3)
    );

    typedef struct {
        logic [1:0]  v;
        logic [4:0]  a0, a1;
        logic [31:0] d0, d1;
        logic        rv;
        logic [4:0]  ra, qa1, qa2;
        logic [1:0]  e_ready;
        logic        e_rsv, e_b1, e_b2, e_we, chk_rf;
        logic [4:0]  e_a3;
        logic [31:0] e_wd;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    function automatic vec_t mk(
        input logic [1:0] v, input logic [4:0] a0, input logic [4:0] a1,
        input logic [31:0] d0, input logic [31:0] d1,
        input logic rv, input logic [4:0] ra, input logic [4:0] qa1, input logic [4:0] qa2,
        input logic [1:0] er, input logic ers, input logic eb1, input logic eb2,
        input logic ewe, input logic cr, input logic [4:0] ea3, input logic [31:0] ewd);
        vec_t t;
        t.v = v; t.a0 = a0; t.a1 = a1; t.d0 = d0; t.d1 = d1;
        t.rv = rv; t.ra = ra; t.qa1 = qa1; t.qa2 = qa2;
        t.e_ready = er; t.e_rsv = ers; t.e_b1 = eb1; t.e_b2 = eb2;
        t.e_we = ewe; t.chk_rf = cr; t.e_a3 = ea3; t.e_wd = ewd;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        req_valid = t.v;
        req_addr  = {t.a1, t.a0};
        req_data  = {t.d1, t.d0};
        rsv_valid = t.rv;
        rsv_addr  = t.ra;
        q_a1      = t.qa1;
        q_a2      = t.qa2;
    endtask

    initial begin
        // Round-robin with both requesters valid
        vecs[0]  = mk(2'b11, 5'd5, 5'd6, 32'hA, 32'hB, 1'b0, 5'd0, 5'd0, 5'd0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 32'hA);
        vecs[1]  = mk(2'b11, 5'd5, 5'd6, 32'hA, 32'hB, 1'b0, 5'd0, 5'd0, 5'd0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd6, 32'hB);
        vecs[2]  = mk(2'b11, 5'd5, 5'd6, 32'hA, 32'hB, 1'b0, 5'd0, 5'd0, 5'd0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 32'hA);
        vecs[3]  = mk(2'b11, 5'd5, 5'd6, 32'hA, 32'hB, 1'b0, 5'd0, 5'd0, 5'd0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd6, 32'hB);
        // Scoreboard lifecycle on x7
        vecs[4]  = mk(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd6, 32'hB);
        vecs[5]  = mk(2'b10, 5'd0, 5'd7, 32'h0, 32'h1234, 1'b0, 5'd0, 5'd7, 5'd0, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 32'h1234);
        vecs[6]  = mk(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 32'h1234);
        vecs[7]  = mk(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 32'h1234);
        // WAW stall on x9
        vecs[8]  = mk(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 32'h1234);
        vecs[9]  = mk(2'b01, 5'd9, 5'd0, 32'h99, 32'h0, 1'b1, 5'd9, 5'd9, 5'd0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 32'h99);
        vecs[10] = mk(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 32'h99);
        vecs[11] = mk(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 32'h99);
        // Same-edge clear and set on x12: set wins
        vecs[12] = mk(2'b10, 5'd0, 5'd12, 32'h0, 32'hC, 1'b0, 5'd0, 5'd12, 5'd9, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd12, 32'hC);
        vecs[13] = mk(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd12, 5'd12, 5'd9, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd12, 32'hC);
        vecs[14] = mk(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd12, 5'd9, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd12, 32'hC);
        // x0 write, reserve and query
        vecs[15] = mk(2'b01, 5'd0, 5'd0, 32'hFFFF, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        vecs[16] = mk(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        vecs[17] = mk(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd12, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        // Idle: pointer must hold at requester 1
        vecs[18] = mk(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        vecs[19] = mk(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        vecs[20] = mk(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        vecs[21] = mk(2'b11, 5'd3, 5'd4, 32'h30, 32'h40, 1'b0, 5'd0, 5'd0, 5'd0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd4, 32'h40);
        vecs[22] = mk(2'b11, 5'd3, 5'd4, 32'h30, 32'h40, 1'b0, 5'd0, 5'd0, 5'd0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 32'h30);

        reset     = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        rsv_valid = 1'b0;
        rsv_addr  = '0;
        q_a1      = 5'd7;
        q_a2      = 5'd9;
        repeat (2) @(posedge clk);
        #1;
        chk("rst rf_we", 64'(rf_we), 64'd0);
        chk("rst rf_a3", 64'(rf_a3), 64'd0);
        chk("rst rf_wd3", 64'(rf_wd3), 64'd0);
        chk("rst q_busy1", 64'(q_busy1), 64'd0);
        chk("rst q_busy2", 64'(q_busy2), 64'd0);
        chk("rst req_ready", 64'(req_ready), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            #1;
            chk($sformatf("v%0d req_ready", i), 64'(req_ready), 64'(vecs[i].e_ready));
            chk($sformatf("v%0d rsv_ready", i), 64'(rsv_ready), 64'(vecs[i].e_rsv));
            chk($sformatf("v%0d q_busy1", i), 64'(q_busy1), 64'(vecs[i].e_b1));
            chk($sformatf("v%0d q_busy2", i), 64'(q_busy2), 64'(vecs[i].e_b2));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d rf_we", i), 64'(rf_we), 64'(vecs[i].e_we));
            if (vecs[i].chk_rf) begin
                chk($sformatf("v%0d rf_a3", i), 64'(rf_a3), 64'(vecs[i].e_a3));
                chk($sformatf("v%0d rf_wd3", i), 64'(rf_wd3), 64'(vecs[i].e_wd));
            end
        end

        // Mid-stream async reset with both requesters valid and x9/x12 busy
        req_valid = 2'b11;
        req_addr  = {5'd4, 5'd3};
        req_data  = {32'h40, 32'h30};
        rsv_valid = 1'b0;
        q_a1      = 5'd9;
        q_a2      = 5'd12;
        #1;
        chk("pre-rst q_busy1", 64'(q_busy1), 64'd1);
        chk("pre-rst q_busy2", 64'(q_busy2), 64'd1);
        chk("pre-rst req_ready", 64'(req_ready), 64'b10);
        #2;
        reset = 1'b1;
        #1;
        chk("mid-rst rf_we", 64'(rf_we), 64'd0);
        chk("mid-rst rf_a3", 64'(rf_a3), 64'd0);
        chk("mid-rst rf_wd3", 64'(rf_wd3), 64'd0);
        chk("mid-rst q_busy1", 64'(q_busy1), 64'd0);
        chk("mid-rst q_busy2", 64'(q_busy2), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("in-rst rf_we", 64'(rf_we), 64'd0);
        reset = 1'b0;
        #1;
        chk("post-rst req_ready", 64'(req_ready), 64'b01);
        @(posedge clk);
        #1;
        chk("post-rst rf_we", 64'(rf_we), 64'd1);
        chk("post-rst rf_a3", 64'(rf_a3), 64'd3);
        chk("post-rst rf_wd3", 64'(rf_wd3), 64'h30);
        chk("post-rst q_busy1", 64'(q_busy1), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
